// File: rtl/conv_encoder.sv
// Rate-1/2, K=9 convolutional encoder with framed input and zero-tail termination.
// One registered output symbol is held behind a valid/ready handshake.
module conv_encoder #(
  parameter logic [8:0]  G0       = 9'o561,
  parameter logic [8:0]  G1       = 9'o753,
  parameter int unsigned TAIL_LEN = 8
) (
  input  logic       Clock1,
  input  logic       Reset,
  input  logic       Active,
  input  logic       FrameStart,
  input  logic [7:0] FrameLen,
  input  logic       InBit,
  input  logic       InValid,
  output logic       InReady,
  output logic [1:0] Symbol,
  output logic       SymValid,
  input  logic       SymReady,
  output logic       SymLast,
  output logic       Busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, TAIL = 2'd2} state_t;

  localparam logic [7:0] TAIL_INIT = TAIL_LEN[7:0];

  state_t     state_reg, state_next;
  logic [7:0] sr_reg, sr_next;
  logic [7:0] data_cnt_reg, data_cnt_next;
  logic [7:0] tail_cnt_reg, tail_cnt_next;
  logic [1:0] symbol_reg, symbol_next;
  logic       sym_valid_reg, sym_valid_next;
  logic       sym_last_reg, sym_last_next;

  logic       out_free;
  logic       accept;
  logic       shift_en;
  logic       shift_bit;
  logic       last_gen;
  logic [8:0] window;
  logic [1:0] parity;

  // The output slot can take a new symbol if it is empty or drains this cycle.
  assign out_free  = ~sym_valid_reg | SymReady;
  assign InReady   = (state_reg == DATA) & Active & out_free;
  assign accept    = InReady & InValid;
  assign shift_en  = accept | ((state_reg == TAIL) & Active & out_free);
  assign shift_bit = (state_reg == DATA) & InBit;
  assign last_gen  = (state_reg == TAIL) & (tail_cnt_reg == 8'd1);
  assign window    = {shift_bit, sr_reg};

  // Symbol[1] uses G0, Symbol[0] uses G1; bit 8 of each generator taps the newest bit.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_parity
      localparam logic [8:0] GEN = (gi == 0) ? G1 : G0;
      assign parity[gi] = ^(GEN & window);
    end
  endgenerate

  // Busy covers the frame until its last symbol has actually left the output slot.
  assign Busy     = (state_reg != IDLE) | sym_last_reg;
  assign Symbol   = symbol_reg;
  assign SymValid = sym_valid_reg;
  assign SymLast  = sym_last_reg;

  always_comb begin
    state_next     = state_reg;
    sr_next        = sr_reg;
    data_cnt_next  = data_cnt_reg;
    tail_cnt_next  = tail_cnt_reg;
    symbol_next    = symbol_reg;
    sym_valid_next = sym_valid_reg;
    sym_last_next  = sym_last_reg;

    if (Active) begin
      case (state_reg)
        IDLE: begin
          if (FrameStart && (FrameLen != 8'd0) && !Busy) begin
            state_next    = DATA;
            data_cnt_next = FrameLen;
          end
        end
        DATA: begin
          if (accept) begin
            data_cnt_next = data_cnt_reg - 8'd1;
            if (data_cnt_reg == 8'd1) begin
              state_next    = TAIL;
              tail_cnt_next = TAIL_INIT;
            end
          end
        end
        TAIL: begin
          if (out_free) begin
            tail_cnt_next = tail_cnt_reg - 8'd1;
            if (tail_cnt_reg == 8'd1) begin
              state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase

      if (shift_en) begin
        sr_next        = last_gen ? 8'd0 : window[8:1];
        symbol_next    = parity;
        sym_valid_next = 1'b1;
        sym_last_next  = last_gen;
      end else if (sym_valid_reg && SymReady) begin
        sym_valid_next = 1'b0;
        sym_last_next  = 1'b0;
      end
    end
  end

  always_ff @(posedge Clock1) begin
    if (!Reset) begin
      state_reg     <= IDLE;
      sr_reg        <= 8'd0;
      data_cnt_reg  <= 8'd0;
      tail_cnt_reg  <= 8'd0;
      symbol_reg    <= 2'd0;
      sym_valid_reg <= 1'b0;
      sym_last_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sr_reg        <= sr_next;
      data_cnt_reg  <= data_cnt_next;
      tail_cnt_reg  <= tail_cnt_next;
      symbol_reg    <= symbol_next;
      sym_valid_reg <= sym_valid_next;
      sym_last_reg  <= sym_last_next;
    end
  end

endmodule

// File: tb/tb_conv_encoder.sv
// Scoreboard bench for conv_encoder: stimulus pushes expected symbols, a
// negedge monitor pops and compares on every output handshake.
module tb_conv_encoder;

  localparam logic [8:0] G0 = 9'o561;
  localparam logic [8:0] G1 = 9'o753;
  localparam int TAIL = 8;

  typedef struct packed {
    logic [1:0] sym;
    logic       last;
  } exp_t;

  logic       Clock1;
  logic       Reset;
  logic       Active;
  logic       FrameStart;
  logic [7:0] FrameLen;
  logic       InBit;
  logic       InValid;
  logic       InReady;
  logic [1:0] Symbol;
  logic       SymValid;
  logic       SymReady;
  logic       SymLast;
  logic       Busy;

  exp_t exp_q[$];
  bit   hist[$];
  logic bits_mem [256];
  logic [1:0] hand_syms [11] = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b10, 2'b01,
                                 2'b00, 2'b01, 2'b11, 2'b00, 2'b00};

  int errors = 0;
  int checks = 0;
  int sym_count = 0;
  int exp_count = 0;
  int lasts = 0;
  int total_syms = 0;
  exp_t mon_e;

  conv_encoder dut (
    .Clock1    (Clock1),
    .Reset     (Reset),
    .Active    (Active),
    .FrameStart(FrameStart),
    .FrameLen  (FrameLen),
    .InBit     (InBit),
    .InValid   (InValid),
    .InReady   (InReady),
    .Symbol    (Symbol),
    .SymValid  (SymValid),
    .SymReady  (SymReady),
    .SymLast   (SymLast),
    .Busy      (Busy)
  );

  initial begin
    Clock1 = 1'b0;
    forever #5 Clock1 = ~Clock1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge Clock1);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: each output is the XOR over the last 9 input bits weighted by the taps.
  function automatic void push_model(input bit b, input bit last);
    exp_t e;
    int n;
    hist.push_back(b);
    n = hist.size() - 1;
    e.sym = 2'b00;
    for (int k = 0; k < 9; k++) begin
      if (n - k >= 0) begin
        e.sym[1] = e.sym[1] ^ (G0[8-k] & hist[n-k]);
        e.sym[0] = e.sym[0] ^ (G1[8-k] & hist[n-k]);
      end
    end
    e.last = last;
    exp_q.push_back(e);
  endfunction

  function automatic void push_hand(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.sym  = hand_syms[k];
      e.last = (k == n - 1);
      exp_q.push_back(e);
    end
  endfunction

  task automatic start_frame(input int len);
    hist.delete();
    exp_count  = len + TAIL;
    FrameStart = 1'b1;
    FrameLen   = len[7:0];
    cyc();
    FrameStart = 1'b0;
    FrameLen   = 8'd0;
  endtask

  task automatic feed(input int len, input int n_feed, input int stall_at,
                      input int poke_at, input bit model, output int iters);
    int i = 0;
    bit stalled = 0;
    bit poked = 0;
    logic acc;
    logic [1:0] held;
    iters = 0;
    while (i < n_feed && iters < len + 50) begin
      InValid = 1'b1;
      InBit   = bits_mem[i];
      if (i == stall_at && !stalled) begin
        stalled  = 1;
        SymReady = 1'b0;
        held     = Symbol;
        repeat (5) begin
          @(negedge Clock1);
          check("stall_inready", InReady, 0);
          check("stall_symbol_held", Symbol, held);
          check("stall_valid_held", SymValid, 1);
          cyc();
        end
        SymReady = 1'b1;
      end
      if (i == poke_at && !poked) begin
        poked      = 1;
        FrameStart = 1'b1;
        FrameLen   = 8'd200;
      end
      @(negedge Clock1);
      acc = InReady;
      cyc();
      if (FrameStart) begin
        FrameStart = 1'b0;
        FrameLen   = 8'd0;
        check("busy_after_poke", Busy, 1);
      end
      if (acc) begin
        if (model) push_model(bits_mem[i], 1'b0);
        i++;
      end
      iters++;
    end
    InValid = 1'b0;
    check("feed_complete", i, n_feed);
    if (model && i == len) begin
      for (int t = 0; t < TAIL; t++) push_model(1'b0, t == TAIL - 1);
    end
  endtask

  task automatic finish_frame(input bit act_stall, output int cycles);
    logic [1:0] hs;
    logic hv, hl;
    cycles = 0;
    if (act_stall) begin
      cyc();
      cyc();
      cycles += 2;
      Active = 1'b0;
      hs = Symbol;
      hv = SymValid;
      hl = SymLast;
      repeat (4) begin
        @(negedge Clock1);
        check("inactive_inready", InReady, 0);
        check("inactive_symbol_held", Symbol, hs);
        check("inactive_valid_held", SymValid, hv);
        check("inactive_last_held", SymLast, hl);
        cyc();
        cycles++;
      end
      Active = 1'b1;
    end
    while (Busy && cycles < 400) begin
      cyc();
      cycles++;
    end
    check("busy_drop", Busy, 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  // Monitor: a symbol is consumed at the next rising edge when valid, ready and active.
  initial begin
    forever begin
      @(negedge Clock1);
      if (Reset && Active && SymValid && SymReady) begin
        total_syms++;
        sym_count++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_symbol: got %b last=%b expected none", Symbol, SymLast);
        end else begin
          mon_e = exp_q.pop_front();
          if (Symbol !== mon_e.sym || SymLast !== mon_e.last) begin
            errors++;
            $display("FAIL symbol_%0d: got %b last=%b expected %b last=%b",
                     sym_count, Symbol, SymLast, mon_e.sym, mon_e.last);
          end
        end
        $display("sym %0d: %b last=%b", sym_count, Symbol, SymLast);
        if (SymLast) begin
          lasts++;
          checks++;
          if (sym_count != exp_count) begin
            errors++;
            $display("FAIL frame_symbol_count: got %0d expected %0d", sym_count, exp_count);
          end
          sym_count = 0;
        end
      end
    end
  end

  initial begin
    int iters;
    int cycles;
    Reset      = 1'b0;
    Active     = 1'b0;
    FrameStart = 1'b0;
    FrameLen   = 8'd0;
    InBit      = 1'b0;
    InValid    = 1'b0;
    SymReady   = 1'b1;
    repeat (3) cyc();
    check("rst_symbol", Symbol, 0);
    check("rst_valid", SymValid, 0);
    check("rst_last", SymLast, 0);
    check("rst_inready", InReady, 0);
    check("rst_busy", Busy, 0);
    Reset  = 1'b1;
    Active = 1'b1;
    cyc();

    // Zero-length frame start is ignored.
    FrameStart = 1'b1;
    FrameLen   = 8'd0;
    cyc();
    FrameStart = 1'b0;
    check("zero_len_busy", Busy, 0);
    cyc();
    check("zero_len_busy_later", Busy, 0);

    // Frame 1: hand-computed 3-bit frame 1,0,0.
    bits_mem[0] = 1'b1;
    bits_mem[1] = 1'b0;
    bits_mem[2] = 1'b0;
    push_hand(11);
    start_frame(3);
    check("f1_busy", Busy, 1);
    feed(3, 3, -1, -1, 1'b0, iters);
    check("f1_feed_cycles", iters, 3);
    finish_frame(1'b0, cycles);
    check("f1_tail_cycles", cycles, 9);

    // Frame 2: output stall mid-DATA plus a FrameStart while busy.
    for (int k = 0; k < 12; k++) bits_mem[k] = $urandom_range(0, 1);
    start_frame(12);
    feed(12, 12, 5, 8, 1'b1, iters);
    finish_frame(1'b0, cycles);

    // Frame 3: Active low for 4 cycles in the tail.
    for (int k = 0; k < 20; k++) bits_mem[k] = $urandom_range(0, 1);
    start_frame(20);
    feed(20, 20, -1, -1, 1'b1, iters);
    finish_frame(1'b1, cycles);

    // Frame 4: reset at the second symbol of a 10-bit frame.
    for (int k = 0; k < 10; k++) bits_mem[k] = 1'b1;
    start_frame(10);
    feed(10, 2, -1, -1, 1'b1, iters);
    Reset = 1'b0;
    cyc();
    check("abort_symbol", Symbol, 0);
    check("abort_valid", SymValid, 0);
    check("abort_last", SymLast, 0);
    check("abort_inready", InReady, 0);
    check("abort_busy", Busy, 0);
    Reset = 1'b1;
    exp_q.delete();
    sym_count = 0;
    cyc();
    check("post_abort_busy", Busy, 0);
    check("post_abort_valid", SymValid, 0);

    // Frame 5: single '1' bit, first symbol must be 11 with a cleared register.
    bits_mem[0] = 1'b1;
    push_hand(9);
    start_frame(1);
    feed(1, 1, -1, -1, 1'b0, iters);
    finish_frame(1'b0, cycles);
    check("f5_tail_cycles", cycles, 9);

    // Frame 6: maximum length, back-to-back.
    for (int k = 0; k < 255; k++) bits_mem[k] = $urandom_range(0, 1);
    start_frame(255);
    feed(255, 255, -1, -1, 1'b1, iters);
    check("f6_feed_cycles", iters, 255);
    finish_frame(1'b0, cycles);
    check("f6_tail_cycles", cycles, 9);

    cyc();
    check("total_symlast", lasts, 5);
    check("total_symbols", total_syms, 11 + 20 + 28 + 1 + 9 + 263);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_encoder.md
CONV_ENCODER -- requirements
Module: conv_encoder

Interface
REQ-001 SHALL have parameter G0, default 9'o561, rate-1/2 generator for Symbol[1]; bit 8 taps the newest input bit.
REQ-002 SHALL have parameter G1, default 9'o753, rate-1/2 generator for Symbol[0]; bit 8 taps the newest input bit.
REQ-003 SHALL have parameter TAIL_LEN, default 8, number of flush bits (K-1, K=9, 256 states).
REQ-004 Clock1  input  1  sole clock; all logic on its rising edge.
REQ-005 Reset  input  1  synchronous, active-low reset.
REQ-006 Active  input  1  global enable; low freezes all state.
REQ-007 FrameStart  input  1  one-cycle pulse that starts a frame.
REQ-008 FrameLen  input  8  number of data bits in the frame, sampled with FrameStart.
REQ-009 InBit  input  1  data bit.
REQ-010 InValid  input  1  InBit is valid.
REQ-011 InReady  output  1  encoder accepts InBit this cycle.
REQ-012 Symbol  output  2  encoded pair {g0 parity, g1 parity}.
REQ-013 SymValid  output  1  Symbol is valid.
REQ-014 SymReady  input  1  downstream accepts Symbol.
REQ-015 SymLast  output  1  marks the final tail symbol of the frame.
REQ-016 Busy  output  1  a frame is in progress (state not IDLE).

Function
REQ-017 SHALL implement a state machine with states IDLE, DATA and TAIL.
REQ-018 IDLE -> DATA SHALL occur on FrameStart=1 with FrameLen != 0; DataCnt loads FrameLen.
REQ-019 FrameStart SHALL be ignored when FrameLen=0, or when the state is not IDLE.
REQ-020 InReady SHALL be (state==DATA) & Active & (~SymValid | SymReady).
REQ-021 On InValid & InReady: SR[7:0] (SR[7] newest) SHALL shift to {InBit, SR[7:1]}; on the next cycle Symbol SHALL be {^(G0 & {InBit,SR}), ^(G1 & {InBit,SR})} with SymValid=1 (1-cycle latency).
REQ-022 Each accepted bit SHALL decrement DataCnt; acceptance of the bit that makes DataCnt reach 0 SHALL move the state to TAIL, with TailCnt loaded to TAIL_LEN.
REQ-023 In TAIL, whenever (~SymValid | SymReady) & Active, the encoder SHALL self-inject InBit=0, emit one symbol per REQ-021, and decrement TailCnt.
REQ-024 The symbol generated when TailCnt goes 1->0 SHALL carry SymLast=1; the state SHALL then return to IDLE with SR=0.
REQ-025 A symbol SHALL be held stable (Symbol, SymValid, SymLast) while SymValid=1 & SymReady=0.
REQ-026 SymValid SHALL clear after a handshake (SymValid & SymReady) when no new symbol is produced in that cycle.
REQ-027 When the handshake and a new symbol occur in the same cycle, the new symbol SHALL replace the old one with no bubble, sustaining 1 symbol/cycle.
REQ-028 With Active=0: no shifting, no counting, no state change, InReady=0; outputs SHALL hold their values.
REQ-029 A frame SHALL produce exactly FrameLen+TAIL_LEN symbols.
REQ-030 Busy SHALL stay 1 until the SymLast symbol has been handshaken.
REQ-031 A new FrameStart SHALL be accepted only when Busy=0.
REQ-032 FrameLen=255 SHALL be supported; the counters SHALL be 8-bit and SHALL never wrap.

Reset
REQ-033 Reset=0 at a clock edge SHALL force state=IDLE, SR=0, DataCnt=0, TailCnt=0, Symbol=0, SymValid=0, SymLast=0, InReady=0, Busy=0, regardless of Active.
REQ-034 Reset asserted mid-frame SHALL abort the frame with no SymLast; the first cycle after release SHALL be IDLE.

Verification
REQ-035 Frame from reset, FrameLen=3, bits 1,0,0, SymReady=1 -> Symbols 11, 01, 11, then 8 tail symbols; SymLast on the 11th; Busy drops after it.
REQ-036 SymReady=0 for 5 cycles mid-DATA -> Symbol/SymValid held; InReady=0; no input lost; sequence identical to the unstalled run.
REQ-037 Active=0 for 4 cycles mid-TAIL -> TailCnt frozen; total symbols still FrameLen+8; SymLast once.
REQ-038 FrameStart with FrameLen=0, then FrameStart during a busy frame -> both ignored; Busy unchanged.
REQ-039 Reset=0 at the 2nd symbol of a 10-bit frame -> all outputs 0 next cycle; a new frame of 1 bit '1' yields 11 first (SR cleared).
REQ-040 FrameLen=255 random bits vs. reference model -> 263 matching symbols, single SymLast, back-to-back throughput 1/cycle.
